// File: rtl/ram_arbiter_2ch_if.sv
// ram_arbiter_2ch_if: client request/response lanes plus the RAM-side
// command and read-data bundle for ram_arbiter_2ch.
interface ram_arbiter_2ch_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              c0_valid;
    logic              c0_we;
    logic [ADDR_W-1:0] c0_addr;
    logic [DATA_W-1:0] c0_wdata;
    logic              c0_ready;
    logic              c0_rvalid;
    logic [DATA_W-1:0] c0_rdata;

    logic              c1_valid;
    logic              c1_we;
    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c1_wdata;
    logic              c1_ready;
    logic              c1_rvalid;
    logic [DATA_W-1:0] c1_rdata;

    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  c0_valid, c0_we, c0_addr, c0_wdata,
        input  c1_valid, c1_we, c1_addr, c1_wdata,
        input  ram_dout,
        output c0_ready, c0_rvalid, c0_rdata,
        output c1_ready, c1_rvalid, c1_rdata,
        output ram_wr_en, ram_wr_addr, ram_din,
        output ram_rd_en, ram_rd_addr
    );

    modport master (
        output c0_valid, c0_we, c0_addr, c0_wdata,
        output c1_valid, c1_we, c1_addr, c1_wdata,
        output ram_dout,
        input  c0_ready, c0_rvalid, c0_rdata,
        input  c1_ready, c1_rvalid, c1_rdata,
        input  ram_wr_en, ram_wr_addr, ram_din,
        input  ram_rd_en, ram_rd_addr
    );
endinterface

// File: rtl/ram_arbiter_2ch.sv
// ram_arbiter_2ch: two clients sharing one registered-read RAM port pair.
// Macro RAM_ARB_RR_EN selects round-robin; undefined gives client 0 priority.
module ram_arbiter_2ch #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    ram_arbiter_2ch_if.slave bus
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic gnt0;
    logic gnt1;
    logic pref0;
    logic acc;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] din_q;
    logic [ADDR_W-1:0] rd_addr_q;

    logic t1_vld_q;
    logic t1_id_q;
    logic t2_vld_q;
    logic t2_id_q;

    logic rv0;
    logic rv1;

    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

`ifdef RAM_ARB_RR_EN
    logic ptr_q;

    // pointer names the preferred client: the one not granted last
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else if (gnt0) begin
            ptr_q <= 1'b1;
        end else if (gnt1) begin
            ptr_q <= 1'b0;
        end
    end

    assign pref0 = !ptr_q;
`else
    assign pref0 = 1'b1;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and grant decision; no grants in INIT or reset
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        unique case (state_q)
            S_INIT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.c0_valid && bus.c1_valid) begin
                    gnt0 = pref0;
                    gnt1 = !pref0;
                end else begin
                    gnt0 = bus.c0_valid;
                    gnt1 = bus.c1_valid;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
        if (!rst) begin
            state_d = S_INIT;
            gnt0    = 1'b0;
            gnt1    = 1'b0;
        end
    end

    assign acc       = gnt0 || gnt1;
    assign sel_we    = gnt1 ? bus.c1_we    : bus.c0_we;
    assign sel_addr  = gnt1 ? bus.c1_addr  : bus.c0_addr;
    assign sel_wdata = gnt1 ? bus.c1_wdata : bus.c0_wdata;

    // stage-2 tag picks which client the RAM read data belongs to
    assign rv0 = t2_vld_q && !t2_id_q;
    assign rv1 = t2_vld_q && t2_id_q;

    // RAM command registers, read-tag pipeline and read-data hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            din_q     <= '0;
            rd_addr_q <= '0;
            t1_vld_q  <= 1'b0;
            t1_id_q   <= 1'b0;
            t2_vld_q  <= 1'b0;
            t2_id_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            wr_en_q  <= acc && sel_we;
            t1_vld_q <= acc && !sel_we;
            t1_id_q  <= gnt1;
            t2_vld_q <= t1_vld_q;
            t2_id_q  <= t1_id_q;
            if (acc && sel_we) begin
                wr_addr_q <= sel_addr;
                din_q     <= sel_wdata;
            end
            if (acc && !sel_we) begin
                rd_addr_q <= sel_addr;
            end
            if (rv0) begin
                rdata0_q <= bus.ram_dout;
            end
            if (rv1) begin
                rdata1_q <= bus.ram_dout;
            end
        end
    end

    assign bus.c0_ready = gnt0;
    assign bus.c1_ready = gnt1;

    // outputs forced low combinationally for the whole reset cycle
    assign bus.ram_wr_en   = rst && wr_en_q;
    assign bus.ram_wr_addr = rst ? wr_addr_q : '0;
    assign bus.ram_din     = rst ? din_q : '0;
    assign bus.ram_rd_en   = rst && t1_vld_q;
    assign bus.ram_rd_addr = rst ? rd_addr_q : '0;

    assign bus.c0_rvalid = rst && rv0;
    assign bus.c1_rvalid = rst && rv1;

    assign bus.c0_rdata = !rst ? '0 :
                          rv0  ? bus.ram_dout : rdata0_q;
    assign bus.c1_rdata = !rst ? '0 :
                          rv1  ? bus.ram_dout : rdata1_q;

endmodule

// File: tb/tb_ram_arbiter_2ch.sv
// tb_ram_arbiter_2ch: directed checks of ram_arbiter_2ch with a
// behavioural registered-read RAM; expectations follow RAM_ARB_RR_EN.
module tb_ram_arbiter_2ch;
    localparam int AW = 4;
    localparam int DW = 8;

`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    logic [DW-1:0] mem [16] = '{default: '0};

    always #5 clk = ~clk;

    ram_arbiter_2ch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter_2ch #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: write on wr_en, registered read one cycle after rd_en
    always @(posedge clk) begin
        if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_din;
        if (bus.ram_rd_en) bus.ram_dout <= mem[bus.ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // write and read never share a cycle
    always @(negedge clk) begin
        if (mon_en) chk("wr_rd_excl", 32'(bus.ram_wr_en & bus.ram_rd_en), 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.c0_valid = v;
        bus.c0_we    = we;
        bus.c0_addr  = a;
        bus.c0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.c1_valid = v;
        bus.c1_we    = we;
        bus.c1_addr  = a;
        bus.c1_wdata = d;
    endtask

    task automatic zero_outs(input string tag);
        chk({tag, "_rdy0"}, 32'(bus.c0_ready), 0);
        chk({tag, "_rdy1"}, 32'(bus.c1_ready), 0);
        chk({tag, "_rv0"}, 32'(bus.c0_rvalid), 0);
        chk({tag, "_rv1"}, 32'(bus.c1_rvalid), 0);
        chk({tag, "_rd0"}, 32'(bus.c0_rdata), 0);
        chk({tag, "_rd1"}, 32'(bus.c1_rdata), 0);
        chk({tag, "_wen"}, 32'(bus.ram_wr_en), 0);
        chk({tag, "_wad"}, 32'(bus.ram_wr_addr), 0);
        chk({tag, "_din"}, 32'(bus.ram_din), 0);
        chk({tag, "_ren"}, 32'(bus.ram_rd_en), 0);
        chk({tag, "_rad"}, 32'(bus.ram_rd_addr), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] exq [$];
        logic [DW-1:0] m0;
        int g;
        int eg;
        int wi;
        int ri;
        int nret;

        // reset two cycles with a pending c0 write
        rst = 1'b0;
        drive0(1'b1, 1'b1, 4'd3, 8'hA5);
        drive1(1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            zero_outs("reset");
            tick();
        end
        rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("init_rdy0", 32'(bus.c0_ready), 0);
        chk("init_rdy1", 32'(bus.c1_ready), 0);
        tick();
        @(negedge clk);
        chk("wr3_rdy0", 32'(bus.c0_ready), 1);

        // read-after-write to addr 3
        tick();
        drive0(1'b1, 1'b0, 4'd3, 8'h00);
        @(negedge clk);
        chk("rd3_rdy0", 32'(bus.c0_ready), 1);
        chk("wr3_wen", 32'(bus.ram_wr_en), 1);
        chk("wr3_wad", 32'(bus.ram_wr_addr), 3);
        chk("wr3_din", 32'(bus.ram_din), 32'hA5);
        chk("wr3_ren", 32'(bus.ram_rd_en), 0);
        tick();
        drive0(1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        chk("rd3_ren", 32'(bus.ram_rd_en), 1);
        chk("rd3_rad", 32'(bus.ram_rd_addr), 3);
        chk("rd3_wen", 32'(bus.ram_wr_en), 0);
        chk("rd3_rv0_early", 32'(bus.c0_rvalid), 0);
        tick();
        @(negedge clk);
        chk("rd3_rv0", 32'(bus.c0_rvalid), 1);
        chk("rd3_data", 32'(bus.c0_rdata), 32'hA5);
        chk("rd3_rv1", 32'(bus.c1_rvalid), 0);
        chk("idle_ren", 32'(bus.ram_rd_en), 0);
        chk("idle_wen", 32'(bus.ram_wr_en), 0);
        tick();
        @(negedge clk);
        chk("rd3_rv0_once", 32'(bus.c0_rvalid), 0);
        chk("rd3_hold", 32'(bus.c0_rdata), 32'hA5);

        // preload addr 1 via c0 and addr 2 via c1, each alone
        tick();
        drive0(1'b1, 1'b1, 4'd1, 8'h11);
        @(negedge clk);
        chk("solo0_rdy0", 32'(bus.c0_ready), 1);
        chk("solo0_rdy1", 32'(bus.c1_ready), 0);
        tick();
        drive0(1'b0, 1'b0, 4'd0, 8'h00);
        drive1(1'b1, 1'b1, 4'd2, 8'h22);
        @(negedge clk);
        chk("solo1_rdy1", 32'(bus.c1_ready), 1);
        chk("solo1_rdy0", 32'(bus.c0_ready), 0);
        chk("wr1_din", 32'(bus.ram_din), 32'h11);
        chk("wr1_wad", 32'(bus.ram_wr_addr), 1);

        // both clients hold reads for four cycles
        for (int j = 0; j < 6; j++) begin
            tick();
            if (j < 4) begin
                drive0(1'b1, 1'b0, 4'd1, 8'h00);
                drive1(1'b1, 1'b0, 4'd2, 8'h00);
            end else begin
                drive0(1'b0, 1'b0, 4'd0, 8'h00);
                drive1(1'b0, 1'b0, 4'd0, 8'h00);
            end
            @(negedge clk);
            if (j == 0) begin
                chk("wr2_din", 32'(bus.ram_din), 32'h22);
                chk("wr2_wad", 32'(bus.ram_wr_addr), 2);
            end
            if (j < 4) begin
                g = RR ? (j % 2) : 0;
                chk("both_rdy0", 32'(bus.c0_ready), 32'(g == 0));
                chk("both_rdy1", 32'(bus.c1_ready), 32'(g == 1));
            end
            if (j >= 2) begin
                eg = RR ? ((j - 2) % 2) : 0;
                chk("both_rv0", 32'(bus.c0_rvalid), 32'(eg == 0));
                chk("both_rv1", 32'(bus.c1_rvalid), 32'(eg == 1));
                if (eg == 0) chk("both_rd0", 32'(bus.c0_rdata), 32'h11);
                else chk("both_rd1", 32'(bus.c1_rdata), 32'h22);
            end else begin
                chk("both_rv0_pre", 32'(bus.c0_rvalid), 0);
                chk("both_rv1_pre", 32'(bus.c1_rvalid), 0);
            end
        end
        chk("c1_rdata_after", 32'(bus.c1_rdata), RR ? 32'h22 : 32'h0);

        // c1 read of addr 5 then one reset cycle: read is discarded
        tick();
        drive1(1'b1, 1'b0, 4'd5, 8'h00);
        @(negedge clk);
        chk("rd5_rdy1", 32'(bus.c1_ready), 1);
        tick();
        drive1(1'b0, 1'b0, 4'd0, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        zero_outs("midrst");
        tick();
        rst = 1'b1;
        drive1(1'b1, 1'b0, 4'd5, 8'h00);
        @(negedge clk);
        chk("post_rst_rdy1", 32'(bus.c1_ready), 0);
        chk("post_rst_rv1_a", 32'(bus.c1_rvalid), 0);
        tick();
        drive1(1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        chk("post_rst_rv1_b", 32'(bus.c1_rvalid), 0);
        tick();
        @(negedge clk);
        chk("post_rst_rv1_c", 32'(bus.c1_rvalid), 0);

        // c0 fills all addresses while c1 keeps reading addr 0
        m0 = mem[0];
        wi = 0;
        ri = 0;
        nret = 0;
        for (int c = 0; c < 48; c++) begin
            if (wi == 16 && nret == 4) break;
            tick();
            drive0(wi < 16, 1'b1, AW'(wi), DW'(8'hC0 + wi));
            drive1(ri < 4, 1'b0, 4'd0, 8'h00);
            @(negedge clk);
            if (bus.c1_rvalid) begin
                if (exq.size() == 0) chk("fill_rv1_spurious", 1, 0);
                else chk("fill_rd0_data", 32'(bus.c1_rdata), 32'(exq.pop_front()));
                nret++;
            end
            chk("fill_rv0_idle", 32'(bus.c0_rvalid), 0);
            chk("fill_one_gnt", 32'(bus.c0_ready & bus.c1_ready), 0);
            if (bus.c0_ready && bus.c0_valid) begin
                if (wi == 0) m0 = 8'hC0;
                wi++;
            end
            if (bus.c1_ready && bus.c1_valid) begin
                exq.push_back(m0);
                ri++;
            end
        end
        chk("fill_wr_count", 32'(wi), 16);
        chk("fill_rd_count", 32'(nret), 4);
        drive0(1'b0, 1'b0, 4'd0, 8'h00);
        drive1(1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        tick();
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            chk("fill_mem", 32'(mem[i]), 32'(8'hC0 + i));
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
